// File: rtl/udp_tx_sched.sv
// udp_tx_sched: transmit scheduler between the I/Q buffer former and the UDP
// transmitter. It latches a finished buffer's descriptor, requests the
// transmitter, tags the packet with a per-channel sequence number, and guards
// the handshake with a watchdog. It then holds an inter-packet gap and returns
// a one-cycle end_tx release pulse. Packet, timeout and drop statistics are
// kept for the control interface.
module udp_tx_sched #(
  parameter int GAP = 50,        // idle clocks between completion and end_tx
  parameter int TMO = 20000000   // watchdog limit in clocks, must be >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        start,
  input  logic [7:0]  channel,
  input  logic [31:0] crc_buf,
  input  logic [15:0] nbuf,
  output logic        tx_req,
  input  logic        tx_ack,
  input  logic        tx_done,
  output logic [7:0]  tx_chan,
  output logic [15:0] tx_len,
  output logic [31:0] tx_crc,
  output logic [15:0] tx_seq,
  output logic        end_tx,
  output logic        busy,
  output logic [31:0] pkt_cnt,
  output logic [15:0] tmo_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DONE,
    S_GAP,
    S_RELEASE
  } state_t;

  localparam logic [31:0] WD_LAST  = 32'(TMO - 1);
  localparam logic [31:0] GAP_LAST = 32'(GAP - 1);
  // With a zero gap the transfer phase hands over directly to RELEASE.
  localparam state_t      AFTER_XFER = (GAP == 0) ? S_RELEASE : S_GAP;
  localparam logic        END_NOW    = (GAP == 0);

  state_t      state;
  logic [31:0] wd_cnt;
  logic [31:0] gap_cnt;
  logic [15:0] seq0;
  logic [15:0] seq1;

  logic accept;
  logic refuse;
  logic success;

  assign accept  = (state == S_IDLE) && start && enable;
  assign refuse  = start && !accept;
  // A completion seen on the watchdog's last cycle still counts as success.
  assign success = ((state == S_REQ) && tx_ack && tx_done) ||
                   ((state == S_WAIT_DONE) && tx_done);

  // Scheduler FSM with registered outputs, counters and statistics.
  // NOTE: all state here uses non-blocking assignments and a synchronous reset
  // so every register updates together on the edge that samples rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wd_cnt   <= '0;
      gap_cnt  <= '0;
      seq0     <= '0;
      seq1     <= '0;
      tx_req   <= 1'b0;
      tx_chan  <= '0;
      tx_len   <= '0;
      tx_crc   <= '0;
      tx_seq   <= '0;
      end_tx   <= 1'b0;
      busy     <= 1'b0;
      pkt_cnt  <= '0;
      tmo_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      tx_req <= 1'b0;
      end_tx <= 1'b0;

      if (refuse && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            tx_chan <= channel;
            tx_len  <= nbuf;
            tx_crc  <= crc_buf;
            tx_seq  <= channel[0] ? seq1 : seq0;
            wd_cnt  <= '0;
            tx_req  <= 1'b1;
            busy    <= 1'b1;
            state   <= S_REQ;
          end
        end

        S_REQ, S_WAIT_DONE: begin
          if (success) begin
            pkt_cnt <= pkt_cnt + 32'd1;
            if (tx_chan[0]) seq1 <= seq1 + 16'd1;
            else            seq0 <= seq0 + 16'd1;
            gap_cnt <= '0;
            end_tx  <= END_NOW;
            state   <= AFTER_XFER;
          end else if (wd_cnt == WD_LAST) begin
            if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
            gap_cnt <= '0;
            end_tx  <= END_NOW;
            state   <= AFTER_XFER;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
            if ((state == S_REQ) && tx_ack) begin
              state <= S_WAIT_DONE;
            end else if (state == S_REQ) begin
              tx_req <= 1'b1;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            end_tx <= 1'b1;
            state  <= S_RELEASE;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end

        S_RELEASE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed self-checking bench for udp_tx_sched. The main instance runs with
// GAP=4 and TMO=100. A second instance with GAP=0 shares the inputs and is
// used to confirm the zero-gap release timing.
module tb_udp_tx_sched;

  localparam int GAP = 4;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        start;
  logic [7:0]  channel;
  logic [31:0] crc_buf;
  logic [15:0] nbuf;
  logic        tx_ack;
  logic        tx_done;

  logic        tx_req;
  logic [7:0]  tx_chan;
  logic [15:0] tx_len;
  logic [31:0] tx_crc;
  logic [15:0] tx_seq;
  logic        end_tx;
  logic        busy;
  logic [31:0] pkt_cnt;
  logic [15:0] tmo_cnt;
  logic [15:0] drop_cnt;

  logic        z_tx_req;
  logic [7:0]  z_tx_chan;
  logic [15:0] z_tx_len;
  logic [31:0] z_tx_crc;
  logic [15:0] z_tx_seq;
  logic        z_end_tx;
  logic        z_busy;
  logic [31:0] z_pkt_cnt;
  logic [15:0] z_tmo_cnt;
  logic [15:0] z_drop_cnt;

  int errors = 0;
  int checks = 0;
  int exp_pkt = 0;

  udp_tx_sched #(.GAP(GAP), .TMO(TMO)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .channel(channel),
    .crc_buf(crc_buf), .nbuf(nbuf), .tx_req(tx_req), .tx_ack(tx_ack),
    .tx_done(tx_done), .tx_chan(tx_chan), .tx_len(tx_len), .tx_crc(tx_crc),
    .tx_seq(tx_seq), .end_tx(end_tx), .busy(busy), .pkt_cnt(pkt_cnt),
    .tmo_cnt(tmo_cnt), .drop_cnt(drop_cnt)
  );

  udp_tx_sched #(.GAP(0), .TMO(TMO)) u_dut0 (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .channel(channel),
    .crc_buf(crc_buf), .nbuf(nbuf), .tx_req(z_tx_req), .tx_ack(tx_ack),
    .tx_done(tx_done), .tx_chan(z_tx_chan), .tx_len(z_tx_len), .tx_crc(z_tx_crc),
    .tx_seq(z_tx_seq), .end_tx(z_end_tx), .busy(z_busy), .pkt_cnt(z_pkt_cnt),
    .tmo_cnt(z_tmo_cnt), .drop_cnt(z_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to the next falling edge and retire one-cycle pulses.
  task automatic step();
    @(negedge clk);
    start   = 1'b0;
    tx_ack  = 1'b0;
    tx_done = 1'b0;
  endtask

  // Called in cycle d+1 after tx_done/timeout; end_tx must rise in the n-th cycle.
  task automatic expect_release(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      check(tag, {31'd0, end_tx}, {31'd0, (i == n)});
      if (i < n) step();
    end
    step();
    check({tag, "_idle"}, {30'd0, busy, end_tx}, 32'd0);
  endtask

  task automatic drive_start(input logic [7:0] ch, input logic [15:0] len, input logic [31:0] crc);
    start   = 1'b1;
    channel = ch;
    nbuf    = len;
    crc_buf = crc;
  endtask

  // Accepted start, same-cycle ack+done, then full gap and release.
  task automatic send_pkt(input string tag, input logic [7:0] ch, input logic [15:0] len,
                          input logic [31:0] crc, input logic [15:0] exp_seq);
    drive_start(ch, len, crc);
    step();
    check({tag, "_req"}, {31'd0, tx_req}, 32'd1);
    check({tag, "_seq"}, {16'd0, tx_seq}, {16'd0, exp_seq});
    check({tag, "_fields"}, {tx_chan, tx_len[7:0], tx_crc[15:0]}, {ch, len[7:0], crc[15:0]});
    tx_ack  = 1'b1;
    tx_done = 1'b1;
    step();
    exp_pkt++;
    check({tag, "_pkt"}, pkt_cnt, exp_pkt);
    expect_release({tag, "_rel"}, GAP + 1);
  endtask

  initial begin
    int  lat;
    bit  found;
    bit  seen;

    rst = 1'b1; enable = 1'b1; start = 1'b0; channel = '0; crc_buf = '0;
    nbuf = '0; tx_ack = 1'b0; tx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ctrl", {29'd0, tx_req, end_tx, busy}, 32'd0);
    check("rst_cnts", pkt_cnt | {16'd0, tmo_cnt} | {16'd0, drop_cnt}, 32'd0);
    check("rst_fields", tx_crc | {tx_chan, tx_len, 8'd0} | {16'd0, tx_seq}, 32'd0);

    // Nominal packet: ack, then done ten cycles later.
    drive_start(8'd0, 16'd1440, 32'h0001_2345);
    step();
    check("nom_req", {30'd0, tx_req, busy}, 32'd3);
    check("nom_chan", {24'd0, tx_chan}, 32'd0);
    check("nom_len", {16'd0, tx_len}, 32'd1440);
    check("nom_crc", tx_crc, 32'h0001_2345);
    check("nom_seq", {16'd0, tx_seq}, 32'd0);
    tx_ack = 1'b1;
    step();
    check("nom_ack_drop_req", {31'd0, tx_req}, 32'd0);
    repeat (9) step();
    check("nom_wait_busy", {30'd0, busy, end_tx}, 32'd2);
    tx_done = 1'b1;
    step();
    exp_pkt = 1;
    check("nom_pkt", pkt_cnt, 32'd1);
    check("gap0_end_tx", {31'd0, z_end_tx}, 32'd1);
    check("gap0_pkt", z_pkt_cnt, 32'd1);
    expect_release("nom_rel", GAP + 1);

    // Alternating channels and same-cycle handshake.
    send_pkt("ch1", 8'd1, 16'd100, 32'hDEAD_BEEF, 16'd0);
    send_pkt("ch0b", 8'd2, 16'd200, 32'h1234_5678, 16'd1);

    // Sequence wrap: preload channel 0 counter to FFFF.
    u_dut.seq0 = 16'hFFFF;
    send_pkt("wrap_ffff", 8'd0, 16'd8, 32'h0000_00AA, 16'hFFFF);
    send_pkt("wrap_zero", 8'd4, 16'd9, 32'h0000_00BB, 16'h0000);

    // Watchdog: no ack, end_tx TMO+GAP cycles after REQ entry.
    drive_start(8'd1, 16'd50, 32'hCAFE_0001);
    step();
    check("wd_seq", {16'd0, tx_seq}, 32'd1);
    found = 1'b0;
    lat = 0;
    for (int i = 1; i <= 300 && !found; i++) begin
      step();
      if (end_tx) begin
        found = 1'b1;
        lat = i;
      end
    end
    check("wd_latency", lat, TMO + GAP);
    check("wd_tmo_cnt", {16'd0, tmo_cnt}, 32'd1);
    check("wd_pkt_cnt", pkt_cnt, exp_pkt);
    step();
    check("wd_idle", {30'd0, busy, tx_req}, 32'd0);
    send_pkt("wd_seq_kept", 8'd1, 16'd60, 32'hCAFE_0002, 16'd1);

    // Success on the watchdog's last cycle beats the timeout.
    drive_start(8'd0, 16'd70, 32'hCAFE_0003);
    step();
    check("edge_seq", {16'd0, tx_seq}, 32'd1);
    repeat (TMO - 1) step();
    check("edge_still_req", {31'd0, tx_req}, 32'd1);
    tx_ack  = 1'b1;
    tx_done = 1'b1;
    step();
    exp_pkt++;
    check("edge_pkt", pkt_cnt, exp_pkt);
    check("edge_tmo", {16'd0, tmo_cnt}, 32'd1);
    expect_release("edge_rel", GAP + 1);

    // Drops: in WAIT_DONE, in RELEASE, and in IDLE with enable low.
    drive_start(8'd0, 16'd64, 32'h0BAD_F00D);
    step();
    check("drop_seq", {16'd0, tx_seq}, 32'd2);
    tx_ack = 1'b1;
    step();
    drive_start(8'd1, 16'd1, 32'h1);
    step();
    check("drop_wait", {16'd0, drop_cnt}, 32'd1);
    check("drop_wait_noeffect", {tx_chan, tx_len[7:0], 15'd0, tx_req}, {8'd0, 8'd64, 16'd0});
    tx_done = 1'b1;
    step();
    exp_pkt++;
    repeat (GAP) step();
    check("drop_rel_end_tx", {31'd0, end_tx}, 32'd1);
    drive_start(8'd0, 16'd2, 32'h2);
    step();
    check("drop_rel", {16'd0, drop_cnt}, 32'd1 + 32'd1);
    check("drop_rel_idle", {29'd0, busy, tx_req, end_tx}, 32'd0);
    enable = 1'b0;
    drive_start(8'd0, 16'd3, 32'h3);
    step();
    enable = 1'b1;
    check("drop_dis", {16'd0, drop_cnt}, 32'd3);
    check("drop_dis_idle", {30'd0, busy, tx_req}, 32'd0);
    step();
    check("drop_no_req", {30'd0, busy, tx_req}, 32'd0);
    check("drop_pkt", pkt_cnt, exp_pkt);

    // Reset during WAIT_DONE aborts the packet without a release pulse.
    drive_start(8'd1, 16'd77, 32'h7777_7777);
    step();
    check("rstw_seq", {16'd0, tx_seq}, 32'd2);
    tx_ack = 1'b1;
    step();
    check("rstw_waiting", {30'd0, busy, tx_req}, 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_ctrl", {29'd0, tx_req, end_tx, busy}, 32'd0);
    check("rstw_cnts", pkt_cnt | {16'd0, tmo_cnt} | {16'd0, drop_cnt}, 32'd0);
    check("rstw_fields", tx_crc | {tx_chan, tx_len, 8'd0} | {16'd0, tx_seq}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (end_tx) seen = 1'b1;
    end
    check("rstw_no_end_tx", {31'd0, seen}, 32'd0);
    exp_pkt = 0;
    send_pkt("rstw_next", 8'd1, 16'd33, 32'h3333_0000, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
